dmem_port_arbiter: RTL and testbench

//  Owns the single data-memory port and shares it between the pipelined core and the UART program/data loader.

---
 rtl/dmem_port_arbiter_pkg.sv | 30 +++
 rtl/dmem_port_arbiter_if.sv | 51 +++++
 rtl/dmem_port_arbiter_rd_tag_pipe.sv | 37 +++
 rtl/dmem_port_arbiter.sv | 144 ++++++++++++++
 tb/tb_dmem_port_arbiter.sv | 251 +++++++++++++++++++++++++
 5 files changed

// File: rtl/dmem_port_arbiter_pkg.sv
// Shared types for the data-memory port arbiter: requester ownership,
// FSM state encoding, read-tag layout and the starvation counter helper.
package dmem_port_arbiter_pkg;

  typedef enum logic {
    OWN_CORE = 1'b0,
    OWN_LDR  = 1'b1
  } owner_e;

  typedef enum logic [1:0] {
    LOAD    = 2'd0,
    RUN     = 2'd1,
    STARVED = 2'd2
  } state_e;

  // One entry of the read-return pipe: which requester a read belongs to.
  typedef struct packed {
    logic   valid;
    owner_e owner;
  } tag_t;

  localparam int WAIT_W = 8;

  // Saturating increment used by the loader starvation counter.
  function automatic logic [WAIT_W-1:0] sat_inc(input logic [WAIT_W-1:0] value,
                                                input logic [WAIT_W-1:0] limit);
    return (value >= limit) ? limit : value + WAIT_W'(1);
  endfunction

endpackage

// File: rtl/dmem_port_arbiter_if.sv
// Bus bundle between the core, the UART loader and the single data-memory
// port. The slave modport is the arbiter's view; master is the far side.
interface dmem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);

  // Core requester
  logic              c_req;
  logic              c_we;
  logic [ADDR_W-1:0] c_addr;
  logic [DATA_W-1:0] c_wdata;
  logic              c_gnt;
  logic              c_rvalid;
  logic [DATA_W-1:0] c_rdata;

  // Loader requester
  logic              l_req;
  logic              l_we;
  logic [ADDR_W-1:0] l_addr;
  logic [DATA_W-1:0] l_wdata;
  logic              l_gnt;
  logic              l_rvalid;
  logic [DATA_W-1:0] l_rdata;

  // Memory port
  logic              m_en;
  logic              m_we;
  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_wdata;
  logic [DATA_W-1:0] m_rdata;

  modport slave (
    input  c_req, c_we, c_addr, c_wdata,
    output c_gnt, c_rvalid, c_rdata,
    input  l_req, l_we, l_addr, l_wdata,
    output l_gnt, l_rvalid, l_rdata,
    output m_en, m_we, m_addr, m_wdata,
    input  m_rdata
  );

  modport master (
    output c_req, c_we, c_addr, c_wdata,
    input  c_gnt, c_rvalid, c_rdata,
    output l_req, l_we, l_addr, l_wdata,
    input  l_gnt, l_rvalid, l_rdata,
    input  m_en, m_we, m_addr, m_wdata,
    output m_rdata
  );

endinterface

// File: rtl/dmem_port_arbiter_rd_tag_pipe.sv
// Read-return tag pipe: carries {valid, owner} alongside the memory's read
// latency so returning data can be steered to the requester that issued it.
module dmem_rd_tag_pipe
  import dmem_port_arbiter_pkg::*;
#(
  parameter int DEPTH = 1
) (
  input  logic clk,
  input  logic rstn,
  input  tag_t tag_in,
  output tag_t tag_out,
  output logic any_valid
);

  tag_t pipe [DEPTH];

  // Shift tags one stage per cycle; reset discards reads in flight.
  always_ff @(posedge clk) begin
    // NOTE: this array is reset on purpose: stale valid bits would emit
    // rvalid for reads that reset dropped. Plain data storage needs no reset.
    if (!rstn) begin
      for (int i = 0; i < DEPTH; i++) pipe[i] <= '0;
    end else begin
      pipe[0] <= tag_in;
      for (int i = 1; i < DEPTH; i++) pipe[i] <= pipe[i-1];
    end
  end

  assign tag_out = pipe[DEPTH-1];

  // Any stage holding a live read keeps the port busy.
  always_comb begin
    any_valid = 1'b0;
    for (int i = 0; i < DEPTH; i++) any_valid = any_valid | pipe[i].valid;
  end

endmodule

// File: rtl/dmem_port_arbiter.sv
// Data-memory port arbiter between the pipelined core and the UART loader.
// LOAD: loader has priority. RUN: core has priority, but a loader denied for
// MAX_WAIT consecutive cycles is forced one grant through STARVED.
// RD_LAT must be 1..4 and MAX_WAIT 1..255.
module dmem_port_arbiter
  import dmem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int RD_LAT   = 1,
  parameter int MAX_WAIT = 8
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 run_mode,
  output logic                 busy,
  dmem_port_arbiter_if.slave   bus
);

  localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MAX_WAIT);

  state_e            state;
  state_e            state_next;
  logic [WAIT_W-1:0] wait_cnt;
  logic [WAIT_W-1:0] wait_next;
  logic              c_gnt;
  logic              l_gnt;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  owner_e            issue_owner;
  tag_t              issue_tag;
  tag_t              rd_tag;
  logic              pipe_busy;
  logic              c_rvalid;
  logic              l_rvalid;

  // Grant priority and next state/counter, decided from requests and state.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path can
    // leave one unassigned and infer a latch.
    c_gnt      = 1'b0;
    l_gnt      = 1'b0;
    state_next = state;
    wait_next  = '0;
    case (state)
      LOAD: begin
        l_gnt = bus.l_req;
        c_gnt = bus.c_req & ~bus.l_req;
        if (run_mode) state_next = RUN;
      end
      RUN: begin
        c_gnt = bus.c_req;
        l_gnt = bus.l_req & ~bus.c_req;
        if (bus.l_req && !l_gnt) wait_next = sat_inc(wait_cnt, WAIT_LIMIT);
        if (wait_next == WAIT_LIMIT) state_next = STARVED;
      end
      STARVED: begin
        // Loader takes the next grant; leave after it or once l_req drops.
        l_gnt      = bus.l_req;
        c_gnt      = bus.c_req & ~bus.l_req;
        state_next = RUN;
      end
      default: state_next = LOAD;
    endcase
    if (!rstn) begin
      c_gnt = 1'b0;
      l_gnt = 1'b0;
    end
  end

  // FSM state and starvation counter registers.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (!rstn) begin
      state    <= LOAD;
      wait_cnt <= '0;
    end else begin
      state    <= state_next;
      wait_cnt <= wait_next;
    end
  end

  // Fields of whichever requester won this cycle.
  always_comb begin
    sel_we    = bus.c_we;
    sel_addr  = bus.c_addr;
    sel_wdata = bus.c_wdata;
    if (l_gnt) begin
      sel_we    = bus.l_we;
      sel_addr  = bus.l_addr;
      sel_wdata = bus.l_wdata;
    end
  end

  // Issue register: a grant in cycle N becomes the memory access in N+1.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      bus.m_en    <= 1'b0;
      bus.m_we    <= 1'b0;
      bus.m_addr  <= '0;
      bus.m_wdata <= '0;
      issue_owner <= OWN_CORE;
    end else begin
      bus.m_en <= c_gnt | l_gnt;
      bus.m_we <= (c_gnt | l_gnt) & sel_we;
      if (c_gnt || l_gnt) begin
        bus.m_addr  <= sel_addr;
        bus.m_wdata <= sel_wdata;
        issue_owner <= l_gnt ? OWN_LDR : OWN_CORE;
      end
    end
  end

  // Only reads need a return tag; it travels with the issued access.
  assign issue_tag.valid = bus.m_en & ~bus.m_we;
  assign issue_tag.owner = issue_owner;

  dmem_rd_tag_pipe #(
    .DEPTH (RD_LAT)
  ) u_tag_pipe (
    .clk       (clk),
    .rstn      (rstn),
    .tag_in    (issue_tag),
    .tag_out   (rd_tag),
    .any_valid (pipe_busy)
  );

  // Steer returning read data to its owner; the other side reads zero.
  always_comb begin
    c_rvalid = rstn & rd_tag.valid & (rd_tag.owner == OWN_CORE);
    l_rvalid = rstn & rd_tag.valid & (rd_tag.owner == OWN_LDR);
  end

  assign bus.c_gnt    = c_gnt;
  assign bus.l_gnt    = l_gnt;
  assign bus.c_rvalid = c_rvalid;
  assign bus.l_rvalid = l_rvalid;
  assign bus.c_rdata  = c_rvalid ? bus.m_rdata : '0;
  assign bus.l_rdata  = l_rvalid ? bus.m_rdata : '0;
  assign busy         = bus.m_en | pipe_busy;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed bench for dmem_port_arbiter. Two instances share clk/rstn:
// dut_a (RD_LAT=1) covers reset, priority, starvation and reset-drop;
// dut_b (RD_LAT=3) covers read routing across the LOAD->RUN switch.
// Inputs change 1ns after posedge; outputs are sampled 2ns after posedge.
module tb_dmem_port_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int RD_LAT_A = 1;
  localparam int RD_LAT_B = 3;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic run_mode_a = 1'b0;
  logic run_mode_b = 1'b0;
  logic busy_a;
  logic busy_b;

  int pass_cnt = 0;
  int total_cnt = 0;

  dmem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus_a ();
  dmem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus_b ();

  dmem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(RD_LAT_A), .MAX_WAIT(8)) dut_a (
    .clk (clk), .rstn (rstn), .run_mode (run_mode_a), .busy (busy_a), .bus (bus_a.slave)
  );

  dmem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(RD_LAT_B), .MAX_WAIT(8)) dut_b (
    .clk (clk), .rstn (rstn), .run_mode (run_mode_b), .busy (busy_b), .bus (bus_b.slave)
  );

  always #5 clk = ~clk;

  // Memory models: write on the access cycle, read data RD_LAT cycles later.
  logic [DW-1:0] mem_a [256];
  logic [DW-1:0] mem_b [256];
  logic [DW-1:0] rd_a [RD_LAT_A];
  logic [DW-1:0] rd_b [RD_LAT_B];

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem_a[i] = '0;
      mem_b[i] = '0;
    end
    for (int i = 0; i < RD_LAT_A; i++) rd_a[i] = '0;
    for (int i = 0; i < RD_LAT_B; i++) rd_b[i] = '0;
  end

  always @(posedge clk) begin
    if (bus_a.m_en && bus_a.m_we) mem_a[bus_a.m_addr[7:0]] <= bus_a.m_wdata;
    rd_a[0] <= mem_a[bus_a.m_addr[7:0]];
    for (int i = 1; i < RD_LAT_A; i++) rd_a[i] <= rd_a[i-1];
  end

  always @(posedge clk) begin
    if (bus_b.m_en && bus_b.m_we) mem_b[bus_b.m_addr[7:0]] <= bus_b.m_wdata;
    rd_b[0] <= mem_b[bus_b.m_addr[7:0]];
    for (int i = 1; i < RD_LAT_B; i++) rd_b[i] <= rd_b[i-1];
  end

  assign bus_a.m_rdata = rd_a[RD_LAT_A-1];
  assign bus_b.m_rdata = rd_b[RD_LAT_B-1];

  // Stimulus helpers
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic a_core(input logic req, input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] wdata);
    bus_a.c_req = req; bus_a.c_we = we; bus_a.c_addr = addr; bus_a.c_wdata = wdata;
  endtask

  task automatic a_ldr(input logic req, input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] wdata);
    bus_a.l_req = req; bus_a.l_we = we; bus_a.l_addr = addr; bus_a.l_wdata = wdata;
  endtask

  task automatic b_core(input logic req, input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] wdata);
    bus_b.c_req = req; bus_b.c_we = we; bus_b.c_addr = addr; bus_b.c_wdata = wdata;
  endtask

  task automatic b_ldr(input logic req, input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] wdata);
    bus_b.l_req = req; bus_b.l_we = we; bus_b.l_addr = addr; bus_b.l_wdata = wdata;
  endtask

  task automatic a_idle();
    a_core(1'b0, 1'b0, '0, '0);
    a_ldr(1'b0, 1'b0, '0, '0);
  endtask

  task automatic b_idle();
    b_core(1'b0, 1'b0, '0, '0);
    b_ldr(1'b0, 1'b0, '0, '0);
  endtask

  // 1: grants suppressed in reset, loader wins the first cycle after release.
  task automatic test_reset();
    rstn = 1'b0;
    a_core(1'b1, 1'b1, 32'h100, 32'h1);
    a_ldr(1'b1, 1'b1, 32'h104, 32'h2);
    b_idle();
    tick(); #1;
    total_cnt++; if (bus_a.l_gnt !== 1'b0) $display("FAIL rst_l_gnt_in_reset: got %b want 0", bus_a.l_gnt); else pass_cnt++;
    tick(); #1;
    total_cnt++; if (bus_a.c_gnt !== 1'b0) $display("FAIL rst_c_gnt_in_reset: got %b want 0", bus_a.c_gnt); else pass_cnt++;
    total_cnt++; if (bus_a.m_en !== 1'b0) $display("FAIL rst_m_en: got %b want 0", bus_a.m_en); else pass_cnt++;
    total_cnt++; if (busy_a !== 1'b0) $display("FAIL rst_busy: got %b want 0", busy_a); else pass_cnt++;
    total_cnt++; if (bus_a.c_rvalid !== 1'b0 || bus_a.l_rvalid !== 1'b0) $display("FAIL rst_rvalid: got c=%b l=%b want 0 0", bus_a.c_rvalid, bus_a.l_rvalid); else pass_cnt++;
    total_cnt++; if (bus_a.m_addr !== 32'h0) $display("FAIL rst_m_addr: got %h want 0", bus_a.m_addr); else pass_cnt++;
    rstn = 1'b1;
    #1;
    total_cnt++; if (bus_a.l_gnt !== 1'b1 || bus_a.c_gnt !== 1'b0) $display("FAIL rst_first_gnt: got l=%b c=%b want l=1 c=0", bus_a.l_gnt, bus_a.c_gnt); else pass_cnt++;
    tick(); a_idle(); #1;
    total_cnt++; if (bus_a.m_en !== 1'b1 || bus_a.m_we !== 1'b1 || bus_a.m_addr !== 32'h104) $display("FAIL rst_first_issue: got en=%b we=%b addr=%h want 1 1 104", bus_a.m_en, bus_a.m_we, bus_a.m_addr); else pass_cnt++;
    tick(); tick();
  endtask

  // 2: loader write then core read in LOAD; read-then-write returns old data.
  task automatic test_load_write_read();
    tick(); a_ldr(1'b1, 1'b1, 32'h40, 32'hDEADBEEF); #1;
    total_cnt++; if (bus_a.l_gnt !== 1'b1) $display("FAIL wr_l_gnt: got %b want 1", bus_a.l_gnt); else pass_cnt++;
    tick(); a_ldr(1'b0, 1'b0, '0, '0); a_core(1'b1, 1'b0, 32'h40, '0); #1;
    total_cnt++; if (bus_a.c_gnt !== 1'b1 || bus_a.l_gnt !== 1'b0) $display("FAIL rd_c_gnt: got c=%b l=%b want 1 0", bus_a.c_gnt, bus_a.l_gnt); else pass_cnt++;
    total_cnt++; if (bus_a.m_en !== 1'b1 || bus_a.m_we !== 1'b1 || bus_a.m_addr !== 32'h40 || bus_a.m_wdata !== 32'hDEADBEEF)
      $display("FAIL wr_issue: got en=%b we=%b addr=%h wdata=%h want 1 1 40 deadbeef", bus_a.m_en, bus_a.m_we, bus_a.m_addr, bus_a.m_wdata); else pass_cnt++;
    tick(); a_idle(); #1;
    total_cnt++; if (bus_a.m_en !== 1'b1 || bus_a.m_we !== 1'b0 || bus_a.c_rvalid !== 1'b0) $display("FAIL rd_issue: got en=%b we=%b rvalid=%b want 1 0 0", bus_a.m_en, bus_a.m_we, bus_a.c_rvalid); else pass_cnt++;
    tick(); #1;
    total_cnt++; if (bus_a.c_rvalid !== 1'b1 || bus_a.c_rdata !== 32'hDEADBEEF) $display("FAIL rd_return: got rvalid=%b rdata=%h want 1 deadbeef", bus_a.c_rvalid, bus_a.c_rdata); else pass_cnt++;
    total_cnt++; if (bus_a.l_rvalid !== 1'b0 || bus_a.l_rdata !== 32'h0) $display("FAIL rd_other_side: got l_rvalid=%b l_rdata=%h want 0 0", bus_a.l_rvalid, bus_a.l_rdata); else pass_cnt++;
    total_cnt++; if (bus_a.m_en !== 1'b0 || busy_a !== 1'b1) $display("FAIL rd_busy_tail: got m_en=%b busy=%b want 0 1", bus_a.m_en, busy_a); else pass_cnt++;
    tick(); #1;
    total_cnt++; if (bus_a.c_rvalid !== 1'b0 || busy_a !== 1'b0) $display("FAIL rd_single_pulse: got rvalid=%b busy=%b want 0 0", bus_a.c_rvalid, busy_a); else pass_cnt++;
    // read, write, read to the same address on consecutive cycles
    tick(); a_ldr(1'b1, 1'b0, 32'h40, '0); #1;
    tick(); a_ldr(1'b1, 1'b1, 32'h40, 32'h12345678); #1;
    tick(); a_ldr(1'b1, 1'b0, 32'h40, '0); #1;
    total_cnt++; if (bus_a.l_rvalid !== 1'b1 || bus_a.l_rdata !== 32'hDEADBEEF) $display("FAIL raw_old_data: got rvalid=%b rdata=%h want 1 deadbeef", bus_a.l_rvalid, bus_a.l_rdata); else pass_cnt++;
    total_cnt++; if (bus_a.c_rvalid !== 1'b0 || bus_a.c_rdata !== 32'h0) $display("FAIL raw_core_quiet: got rvalid=%b rdata=%h want 0 0", bus_a.c_rvalid, bus_a.c_rdata); else pass_cnt++;
    tick(); a_idle(); #1;
    total_cnt++; if (bus_a.l_rvalid !== 1'b0) $display("FAIL raw_write_no_rvalid: got %b want 0", bus_a.l_rvalid); else pass_cnt++;
    tick(); #1;
    total_cnt++; if (bus_a.l_rvalid !== 1'b1 || bus_a.l_rdata !== 32'h12345678) $display("FAIL raw_new_data: got rvalid=%b rdata=%h want 1 12345678", bus_a.l_rvalid, bus_a.l_rdata); else pass_cnt++;
    tick(); #1;
    total_cnt++; if (busy_a !== 1'b0) $display("FAIL raw_idle: got busy=%b want 0", busy_a); else pass_cnt++;
  endtask

  // 6: both request every cycle in LOAD; loader takes all 16 grants.
  task automatic test_load_tie();
    int lg = 0;
    int cg = 0;
    for (int k = 0; k < 16; k++) begin
      tick();
      a_core(1'b1, 1'b0, 32'h200, '0);
      a_ldr(1'b1, 1'b1, 32'h80 + 32'(k), 32'hC0DE0000 + 32'(k));
      #1;
      lg += int'(bus_a.l_gnt);
      cg += int'(bus_a.c_gnt);
      if (k > 0) begin
        total_cnt++; if (busy_a !== 1'b1 || bus_a.m_addr !== 32'h80 + 32'(k - 1))
          $display("FAIL tie_issue_%0d: got busy=%b addr=%h want 1 %h", k, busy_a, bus_a.m_addr, 32'h80 + 32'(k - 1)); else pass_cnt++;
      end
    end
    tick(); a_idle(); #1;
    total_cnt++; if (bus_a.m_en !== 1'b1 || busy_a !== 1'b1 || bus_a.m_wdata !== 32'hC0DE000F) $display("FAIL tie_last_issue: got en=%b busy=%b wdata=%h want 1 1 c0de000f", bus_a.m_en, busy_a, bus_a.m_wdata); else pass_cnt++;
    total_cnt++; if (lg !== 16 || cg !== 0) $display("FAIL tie_counts: got l=%0d c=%0d want 16 0", lg, cg); else pass_cnt++;
    tick(); #1;
    total_cnt++; if (bus_a.m_en !== 1'b0 || busy_a !== 1'b0 || bus_a.m_addr !== 32'h8F) $display("FAIL tie_hold: got en=%b busy=%b addr=%h want 0 0 8f", bus_a.m_en, busy_a, bus_a.m_addr); else pass_cnt++;
  endtask

  // 3: RUN starvation: loader forced through on the 9th and 18th denied cycle.
  task automatic test_starvation();
    logic exp_l;
    tick(); run_mode_a = 1'b1; #1;
    for (int k = 1; k <= 18; k++) begin
      tick();
      a_core(1'b1, 1'b1, 32'h300, 32'(k));
      a_ldr(1'b1, 1'b1, 32'h304, 32'(k));
      if (k == 3) run_mode_a = 1'b0;
      #1;
      exp_l = (k == 9) || (k == 18);
      total_cnt++; if (bus_a.l_gnt !== exp_l || bus_a.c_gnt !== !exp_l)
        $display("FAIL starve_cycle_%0d: got l=%b c=%b want l=%b c=%b", k, bus_a.l_gnt, bus_a.c_gnt, exp_l, !exp_l); else pass_cnt++;
    end
    tick(); a_idle(); tick(); tick();
  endtask

  // 5: reset right after a core read drops it; arbiter restarts in LOAD.
  task automatic test_reset_drop();
    tick(); a_core(1'b1, 1'b0, 32'h40, '0); #1;
    total_cnt++; if (bus_a.c_gnt !== 1'b1) $display("FAIL rstdrop_c_gnt: got %b want 1", bus_a.c_gnt); else pass_cnt++;
    tick(); a_idle(); rstn = 1'b0; #1;
    tick(); rstn = 1'b1; #1;
    total_cnt++; if (bus_a.c_rvalid !== 1'b0 || bus_a.l_rvalid !== 1'b0 || bus_a.c_rdata !== 32'h0)
      $display("FAIL rstdrop_rvalid: got c=%b l=%b rdata=%h want 0 0 0", bus_a.c_rvalid, bus_a.l_rvalid, bus_a.c_rdata); else pass_cnt++;
    total_cnt++; if (bus_a.m_en !== 1'b0 || bus_a.m_we !== 1'b0 || bus_a.m_addr !== 32'h0 || bus_a.m_wdata !== 32'h0 || busy_a !== 1'b0)
      $display("FAIL rstdrop_outputs: got en=%b we=%b addr=%h wdata=%h busy=%b want all 0", bus_a.m_en, bus_a.m_we, bus_a.m_addr, bus_a.m_wdata, busy_a); else pass_cnt++;
    tick(); a_core(1'b1, 1'b1, 32'h50, 32'h1); a_ldr(1'b1, 1'b1, 32'h54, 32'h2); #1;
    total_cnt++; if (bus_a.l_gnt !== 1'b1 || bus_a.c_gnt !== 1'b0) $display("FAIL rstdrop_load_state: got l=%b c=%b want 1 0", bus_a.l_gnt, bus_a.c_gnt); else pass_cnt++;
    tick(); a_idle(); tick(); tick();
  endtask

  // 4: RD_LAT=3, loader read then core read across LOAD->RUN; both routed.
  task automatic test_mode_switch();
    tick(); b_ldr(1'b1, 1'b1, 32'h10, 32'hAAAA0010); #1;
    total_cnt++; if (bus_b.l_gnt !== 1'b1) $display("FAIL sw_preload_gnt: got %b want 1", bus_b.l_gnt); else pass_cnt++;
    tick(); b_ldr(1'b1, 1'b1, 32'h20, 32'hCCCC0020);
    tick(); b_idle(); tick(); tick();
    tick(); b_ldr(1'b1, 1'b0, 32'h10, '0); #1;
    total_cnt++; if (bus_b.l_gnt !== 1'b1) $display("FAIL sw_l_gnt: got %b want 1", bus_b.l_gnt); else pass_cnt++;
    tick(); b_ldr(1'b0, 1'b0, '0, '0); run_mode_b = 1'b1; b_core(1'b1, 1'b0, 32'h20, '0); #1;
    total_cnt++; if (bus_b.c_gnt !== 1'b1) $display("FAIL sw_c_gnt: got %b want 1", bus_b.c_gnt); else pass_cnt++;
    for (int k = 2; k <= 6; k++) begin
      tick();
      if (k == 2) b_idle();
      #1;
      total_cnt++; if (bus_b.l_rvalid !== (k == 4) || bus_b.c_rvalid !== (k == 5))
        $display("FAIL sw_rvalid_n%0d: got l=%b c=%b want l=%b c=%b", k, bus_b.l_rvalid, bus_b.c_rvalid, (k == 4), (k == 5)); else pass_cnt++;
      if (k == 4) begin
        total_cnt++; if (bus_b.l_rdata !== 32'hAAAA0010 || bus_b.c_rdata !== 32'h0) $display("FAIL sw_l_data: got l=%h c=%h want aaaa0010 0", bus_b.l_rdata, bus_b.c_rdata); else pass_cnt++;
      end
      if (k == 5) begin
        total_cnt++; if (bus_b.c_rdata !== 32'hCCCC0020 || bus_b.l_rdata !== 32'h0) $display("FAIL sw_c_data: got c=%h l=%h want cccc0020 0", bus_b.c_rdata, bus_b.l_rdata); else pass_cnt++;
      end
    end
    tick(); b_core(1'b1, 1'b1, 32'h30, 32'h3); b_ldr(1'b1, 1'b1, 32'h34, 32'h4); #1;
    total_cnt++; if (bus_b.c_gnt !== 1'b1 || bus_b.l_gnt !== 1'b0) $display("FAIL sw_run_priority: got c=%b l=%b want 1 0", bus_b.c_gnt, bus_b.l_gnt); else pass_cnt++;
    tick(); b_idle(); tick(); tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    a_idle();
    b_idle();
    test_reset();
    test_load_write_read();
    test_load_tie();
    test_starvation();
    test_reset_drop();
    test_mode_switch();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
